tama_action_decoder: RTL

TAMA_ACTION_DECODER -- requirements
Module: tama_action_decoder

---
 rtl/tama_pkg.sv | 39 +++
 rtl/tama_debounce.sv | 37 +++
 rtl/tama_action_decoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tama_pkg.sv
// Shared constants, FSM state type and priority-select helper for the Tamagotchi action decoder.
package tama_pkg;

  localparam int unsigned NUM_BTN   = 6;
  localparam int unsigned NUM_IN    = 7;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned REPEAT_W  = 24;

  localparam logic [CODE_W-1:0] ACT_NONE     = 3'd0;
  localparam logic [CODE_W-1:0] ACT_FEED     = 3'd1;
  localparam logic [CODE_W-1:0] ACT_PLAY     = 3'd2;
  localparam logic [CODE_W-1:0] ACT_MEDICINE = 3'd3;
  localparam logic [CODE_W-1:0] ACT_CLEAN    = 3'd4;
  localparam logic [CODE_W-1:0] ACT_SLEEP    = 3'd5;
  localparam logic [CODE_W-1:0] ACT_TALK     = 3'd6;

  localparam int unsigned BTN_FEED     = 0;
  localparam int unsigned BTN_PLAY     = 1;
  localparam int unsigned BTN_MEDICINE = 2;
  localparam int unsigned BTN_CLEAN    = 3;
  localparam int unsigned BTN_SLEEP    = 4;
  localparam int unsigned BTN_TALK     = 5;
  localparam int unsigned PAUSE_BIT    = 6;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    lowest_set = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/tama_debounce.sv
// Two-flop synchronizer followed by a saturating-window debouncer for one input bit.
module tama_debounce
  import tama_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_COUNT = 16'd50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_COUNT - 16'd1) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/tama_action_decoder.sv
// Button capture and one-at-a-time action offer to the stats consumer.
// Optional auto-repeat of held buttons is enabled by defining ACTION_REPEAT_EN.
module tama_action_decoder
  import tama_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_COUNT = 16'd50_000,
  parameter logic [23:0] REPEAT_COUNT   = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic              action_ack,
  output logic              action_valid,
  output logic [CODE_W-1:0] action_code,
  output logic [NUM_BTN-1:0] pending,
  output logic              dropped
);

  logic [NUM_IN-1:0]  stable;
  logic [NUM_BTN-1:0] stable_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] rep_fire;
  logic [NUM_BTN-1:0] set_vec;
  logic [NUM_BTN-1:0] clr_vec;
  logic [NUM_BTN-1:0] pending_nxt;
  logic               dropped_nxt;
  logic               pause;
  logic               unused_in;

  state_e             state;
  state_e             state_nxt;
  logic               valid_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic [CODE_W-1:0]  offer_idx;
  logic [CODE_W-1:0]  offer_idx_nxt;

  assign unused_in = ui_in[7];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    tama_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (ui_in[i]),
      .stable (stable[i])
    );
  end

  assign pause = stable[PAUSE_BIT];
  assign rise  = stable[NUM_BTN-1:0] & ~stable_q;

`ifdef ACTION_REPEAT_EN
  logic [REPEAT_W-1:0] rep_timer [NUM_BTN];

  // Timer runs only while a button is held high; it restarts on each rising edge.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rep_fire[i] = stable[i] & stable_q[i] & (rep_timer[i] == REPEAT_COUNT - 24'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) rep_timer[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!(stable[i] & stable_q[i]) || rep_fire[i]) rep_timer[i] <= '0;
        else rep_timer[i] <= rep_timer[i] + 24'd1;
      end
    end
  end
`else
  logic [REPEAT_W-1:0] unused_repeat_count;
  assign unused_repeat_count = REPEAT_COUNT;
  assign rep_fire = '0;
`endif

  // Capture and accept; a new set on the bit being acked wins over the clear.
  always_comb begin
    set_vec     = (rise | rep_fire) & {NUM_BTN{ena}};
    clr_vec     = '0;
    if (state == S_OFFER && action_ack) clr_vec = NUM_BTN'(1) << offer_idx;
    pending_nxt = (pending & ~clr_vec) | set_vec;
    dropped_nxt = dropped | (|(set_vec & pending & ~clr_vec));
  end

  always_comb begin
    state_nxt     = state;
    valid_nxt     = action_valid;
    code_nxt      = action_code;
    offer_idx_nxt = offer_idx;
    case (state)
      S_IDLE: begin
        if ((|pending) && !pause && ena) begin
          offer_idx_nxt = lowest_set(pending);
          valid_nxt     = 1'b1;
          code_nxt      = offer_idx_nxt + 3'd1;
          state_nxt     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (action_ack) begin
          valid_nxt = 1'b0;
          code_nxt  = ACT_NONE;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        code_nxt  = ACT_NONE;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      action_valid <= 1'b0;
      action_code  <= ACT_NONE;
      offer_idx    <= '0;
      pending      <= '0;
      dropped      <= 1'b0;
      stable_q     <= '0;
    end else begin
      state        <= state_nxt;
      action_valid <= valid_nxt;
      action_code  <= code_nxt;
      offer_idx    <= offer_idx_nxt;
      pending      <= pending_nxt;
      dropped      <= dropped_nxt;
      stable_q     <= stable[NUM_BTN-1:0];
    end
  end

endmodule
